mux8x1_rr_scheduler: RTL and testbench

MUX8X1_RR_SCHEDULER -- requirements
Module: mux8x1_rr_scheduler

---
 rtl/mux8x1_pkg.sv | 21 ++
 rtl/mux8x1_rr_scheduler_rr_pick8.sv | 43 ++++
 rtl/mux8x1_rr_scheduler.sv | 96 +++++++++
 tb/tb_mux8x1_rr_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux8x1_pkg.sv
// Shared types and constants for the 8:1 round-robin scheduler.
// Lane count, select width, the IDLE/HOLD state type and a one-hot helper.
package mux8x1_pkg;

    localparam int N_LANES = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // One-hot lane mask for a lane index
    function automatic logic [N_LANES-1:0] lane_onehot(input logic [SEL_W-1:0] idx);
        logic [N_LANES-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/mux8x1_rr_scheduler_rr_pick8.sv
// rr_pick8: combinational lane picker for the 8:1 scheduler.
// Default: round-robin, first requesting lane at or after ptr, wrapping 7->0.
// MUX8X1_FIXED_PRIO_EN: fixed priority, lowest requesting index wins, ptr ignored.
module rr_pick8
    import mux8x1_pkg::*;
(
    input  logic [N_LANES-1:0] v,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

`ifdef MUX8X1_FIXED_PRIO_EN
    // Walk from the highest index down so the lowest requesting lane is the last writer
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (v[i]) begin
                found = 1'b1;
                idx   = SEL_W'(i);
            end
        end
    end
`else
    logic [SEL_W-1:0] lane;

    // Walk offsets from farthest to nearest so the lane closest to ptr is the last writer
    always_comb begin
        found = 1'b0;
        idx   = '0;
        lane  = '0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            lane = ptr + SEL_W'(i);
            if (v[lane]) begin
                found = 1'b1;
                idx   = lane;
            end
        end
    end
`endif

endmodule

// File: rtl/mux8x1_rr_scheduler.sv
// mux8x1_rr_scheduler: captures one requesting lane's data bit into a y/s pair
// for a downstream 1x8 demux. Round-robin by default; define
// MUX8X1_FIXED_PRIO_EN for fixed lowest-index priority (SCAN_START then unused).
//
// Handshake: the y/s pair transfers on a rising edge where out_valid=1 and
// out_ready=1. While out_valid=1 and out_ready=0, y and s hold stable. The
// requester side sees ack[k] for one cycle on the edge that samples d[k],
// and must drop v[k] in the following cycle.
module mux8x1_rr_scheduler
    import mux8x1_pkg::*;
#(
    parameter int SCAN_START = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LANES-1:0] d,
    input  logic [N_LANES-1:0] v,
    input  logic               out_ready,
    output logic               y,
    output logic [SEL_W-1:0]   s,
    output logic               out_valid,
    output logic [N_LANES-1:0] ack,
    output state_t             state_dbg
);

    state_t           state;
    state_t           state_nx;
    logic             capture;
    logic [SEL_W-1:0] ptr;
    logic             found;
    logic [SEL_W-1:0] pick;

    rr_pick8 u_pick (
        .v     (v),
        .ptr   (ptr),
        .found (found),
        .idx   (pick)
    );

    // Next state and capture decision: capture whenever the slot is free or being freed this edge
    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    capture  = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (found) begin
                        capture = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Held pair, ack pulse and scan pointer; d is sampled only on a capture edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y   <= 1'b0;
            s   <= '0;
            ack <= '0;
            ptr <= SEL_W'(SCAN_START);
        end else begin
            ack <= '0;
            if (capture) begin
                y   <= d[pick];
                s   <= pick;
                ack <= lane_onehot(pick);
`ifndef MUX8X1_FIXED_PRIO_EN
                ptr <= pick + SEL_W'(1);
`endif
            end
        end
    end

    assign out_valid = (state == HOLD);
    assign state_dbg = state;

endmodule

// File: tb/tb_mux8x1_rr_scheduler.sv
// Bench for mux8x1_rr_scheduler: reset checks, a vector table, directed
// multi-cycle sequences and a randomized phase against a lane-order model.
module tb_mux8x1_rr_scheduler;
    import mux8x1_pkg::*;

    localparam int SCAN_START = 0;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst;
    logic [7:0] d;
    logic [7:0] v;
    logic       out_ready;
    logic       y;
    logic [2:0] s;
    logic       out_valid;
    logic [7:0] ack;
    state_t     state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mux8x1_rr_scheduler #(.SCAN_START(SCAN_START)) dut (
        .clk       (clk),
        .rst       (rst),
        .d         (d),
        .v         (v),
        .out_ready (out_ready),
        .y         (y),
        .s         (s),
        .out_valid (out_valid),
        .ack       (ack),
        .state_dbg (state_dbg)
    );

    // ---------------- counters ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // The model keeps: whether a pair is held, the held pair, and the next lane to scan from.
    bit       m_hold;
    bit       m_y;
    int       m_s;
    int       m_ptr;

    task automatic model_reset();
        m_hold = 0;
        m_y    = 0;
        m_s    = 0;
        m_ptr  = SCAN_START;
    endtask

    // Returns {valid, y, s, ack} expected after the coming edge
    task automatic model_step(input logic [7:0] mv, input logic [7:0] md, input logic mr,
                              output logic [12:0] e);
        int order[$];
        int k;
        logic [7:0] m_ack;
        m_ack = 8'h00;
        if (!m_hold || mr) begin
            order = {};
            for (int j = 0; j < 8; j++) begin
`ifdef MUX8X1_FIXED_PRIO_EN
                order.push_back(j);
`else
                order.push_back((m_ptr + j) % 8);
`endif
            end
            k = -1;
            foreach (order[j]) if (k < 0 && mv[order[j]]) k = order[j];
            if (k >= 0) begin
                m_hold   = 1;
                m_y      = md[k];
                m_s      = k;
                m_ack    = 8'h01 << k;
                m_ptr    = (k + 1) % 8;
            end else begin
                m_hold = 0;
            end
        end
        e = {m_hold, m_y, 3'(m_s), m_ack};
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs, keep model in sync, advance one edge
    task automatic drive(input logic [7:0] nv, input logic [7:0] nd, input logic nr);
        logic [12:0] e;
        v = nv; d = nd; out_ready = nr;
        model_step(nv, nd, nr, e);
        tick();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] v;
        logic [7:0] d;
        logic       r;
        logic       e_valid;
        logic       e_y;
        logic [2:0] e_s;
        logic [7:0] e_ack;
    } vec_t;

    vec_t tbl[7];

    function automatic vec_t mk(logic [7:0] vv, logic [7:0] dd, logic r, logic ev,
                                logic ey, logic [2:0] es, logic [7:0] ea);
        vec_t t;
        t.v = vv; t.d = dd; t.r = r; t.e_valid = ev; t.e_y = ey; t.e_s = es; t.e_ack = ea;
        return t;
    endfunction

    // ---------------- scoreboard ----------------
    logic [12:0] exp_q[$];

    initial begin
        logic [12:0] e;
        logic [12:0] got;
        rst = 1'b1; v = '0; d = '0; out_ready = 1'b0;
        model_reset();
        #2;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_y",     32'(y), 0);
        chk("rst_s",     32'(s), 0);
        chk("rst_ack",   32'(ack), 0);
        chk("rst_state", 32'(state_dbg), 32'(IDLE));
        tick();
        rst = 1'b0;

        // Table: single lane, return to idle, capture from idle with ready low, stall, hand-off
        tbl[0] = mk(8'h00, 8'h00, 1, 0, 0, 3'd0, 8'h00);
        tbl[1] = mk(8'h04, 8'h04, 1, 1, 1, 3'd2, 8'h04);
        tbl[2] = mk(8'h00, 8'hFF, 1, 0, 0, 3'd0, 8'h00);
        tbl[3] = mk(8'h80, 8'h80, 0, 1, 1, 3'd7, 8'h80);
        tbl[4] = mk(8'h01, 8'h00, 0, 1, 1, 3'd7, 8'h00);
        tbl[5] = mk(8'h01, 8'h00, 1, 1, 0, 3'd0, 8'h01);
        tbl[6] = mk(8'h00, 8'h00, 1, 0, 0, 3'd0, 8'h00);
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].r);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_ack", i),   32'(ack),       32'(tbl[i].e_ack));
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_y", i), 32'(y), 32'(tbl[i].e_y));
                chk($sformatf("tbl%0d_s", i), 32'(s), 32'(tbl[i].e_s));
            end
        end

`ifndef MUX8X1_FIXED_PRIO_EN
        // Round-robin sweep from SCAN_START with every lane requesting
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            drive(8'hFF, 8'hA5, 1);
            chk($sformatf("rr%0d_s", i),     32'(s), 32'(i % 8));
            chk($sformatf("rr%0d_y", i),     32'(y), 32'((8'hA5 >> (i % 8)) & 1));
            chk($sformatf("rr%0d_ack", i),   32'(ack), 32'(8'h01 << (i % 8)));
            chk($sformatf("rr%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("rr%0d_onehot", i), 32'($countones(ack)), 1);
        end
        drive(8'h00, 8'h00, 1);
        chk("rr_end_valid", 32'(out_valid), 0);

        // Wrap: lane 6 moves the pointer to 7, then lane 7 before lane 0
        drive(8'h40, 8'h00, 1);
        chk("wrap_pre_s", 32'(s), 6);
        drive(8'h81, 8'h00, 1);
        chk("wrap_s7", 32'(s), 7);
        drive(8'h01, 8'h00, 1);
        chk("wrap_s0", 32'(s), 0);
        chk("wrap_ack0", 32'(ack), 32'h01);
        drive(8'h00, 8'h00, 1);
        chk("wrap_idle", 32'(out_valid), 0);

        // Backpressure with lane 3 held; d[3] flips meanwhile and must not leak into y
        drive(8'h08, 8'h08, 0);
        chk("bp_cap_s", 32'(s), 3);
        chk("bp_cap_y", 32'(y), 1);
        for (int i = 0; i < 4; i++) begin
            drive(8'h10, 8'h00, 0);
            chk($sformatf("bp%0d_s", i),     32'(s), 3);
            chk($sformatf("bp%0d_y", i),     32'(y), 1);
            chk($sformatf("bp%0d_ack", i),   32'(ack), 0);
            chk($sformatf("bp%0d_valid", i), 32'(out_valid), 1);
        end
        drive(8'h10, 8'h00, 1);
        chk("bp_rel_s", 32'(s), 4);
        chk("bp_rel_ack", 32'(ack), 32'h10);
        drive(8'h00, 8'h00, 1);
        chk("bp_idle", 32'(out_valid), 0);
`else
        // Fixed priority: every capture goes to lane 0 while all lanes request
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(8'hFF, 8'h01, 1);
            chk($sformatf("fp%0d_s", i),   32'(s), 0);
            chk($sformatf("fp%0d_ack", i), 32'(ack), 32'h01);
        end
        drive(8'h00, 8'h00, 1);
`endif

        // Asynchronous reset while holding lane 5
        apply_reset();
        drive(8'h20, 8'h20, 0);
        chk("ar_pre_s", 32'(s), 5);
        chk("ar_pre_valid", 32'(out_valid), 1);
        v = 8'h00;
        rst = 1'b1;
        model_reset();
        #1;
        chk("ar_valid", 32'(out_valid), 0);
        chk("ar_s",     32'(s), 0);
        chk("ar_y",     32'(y), 0);
        chk("ar_ack",   32'(ack), 0);
        tick();
        rst = 1'b0;
        drive(8'h00, 8'h00, 1);
        chk("ar_idle0", 32'(out_valid), 0);
        drive(8'h00, 8'h00, 0);
        chk("ar_idle1", 32'(out_valid), 0);
        chk("ar_idle_ack", 32'(ack), 0);

        // Randomized phase against the model
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 49) == 0) begin
                apply_reset();
                chk("rnd_rst_valid", 32'(out_valid), 0);
            end else begin
                v = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom & $urandom);
                d = 8'($urandom);
                out_ready = ($urandom_range(0, 3) != 0);
                model_step(v, d, out_ready, e);
                exp_q.push_back(e);
                tick();
                got = exp_q.pop_front();
                chk("rnd_valid", 32'(out_valid), 32'(got[12]));
                chk("rnd_ack",   32'(ack),       32'(got[7:0]));
                if (got[12]) begin
                    chk("rnd_y", 32'(y), 32'(got[11]));
                    chk("rnd_s", 32'(s), 32'(got[10:8]));
                end
            end
        end

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
